mult_hilo_ctrl: RTL and testbench
=================================

Name: mult_hilo_ctrl

Overview:
Sequencing controller for the 32-iteration shift-add multiplier datapath (opcode MULT = 25).
- Accepts MULT/MFHI/MFLO requests through a valid/ready handshake.
- Loads operands into the multiplier, counts its iterations, and captures the 64-bit product into HI/LO.
- Returns HI or LO on MFHI/MFLO.
- Sits between the ALU-control decode stage and the multiplier instance.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH.
CYCLES, 32, multiplier iterations before the product is valid.
MULT_OP, 6'd25, multiply opcode.
MFHI_OP, 6'd16, read-HI opcode.
MFLO_OP, 6'd18, read-LO opcode.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low; 0 = reset.
req_valid  in  1  request present.
req_ready  out  1  request can be accepted.
signal  in  6  opcode of request.
src_a  in  WIDTH  multiplicand.
src_b  in  WIDTH  multiplier.
mul_load  out  1  drives the multiplier's load/clear input (active-high).
mul_dataA  out  2*WIDTH  multiplicand to multiplier.
mul_dataB  out  WIDTH  multiplier operand to multiplier.
mul_result  in  2*WIDTH  multiplier product.
rd_data  out  WIDTH  MFHI/MFLO result.
rd_valid  out  1  rd_data valid, one-cycle pulse.
done  out  1  MULT complete, one-cycle pulse.
busy  out  1  MULT in progress.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - hi, lo, rd_data, counter = 0.
  - rd_valid, done, busy, mul_load = 0.
  - Operand registers = 0.
  - req_ready = 0 while reset is low and 1 once in IDLE.
- Handshake:
  - A request is accepted on a clock edge where req_valid && req_ready.
  - req_ready = 1 only in IDLE.
- States:
  - IDLE, accept MULT: latch src_a/src_b into operand registers, go to LOAD.
  - IDLE, accept MFHI: rd_data <= hi, rd_valid pulses next cycle, stay IDLE.
  - IDLE, accept MFLO: same as MFHI but with lo.
  - IDLE, accept other opcode: consume, no effect, no pulse.
  - LOAD (1 cycle): mul_load = 1; mul_dataA = zero-extended operand A; mul_dataB = operand B. counter <= 0. Go to RUN.
  - RUN: mul_load = 0; counter increments each cycle. When counter == CYCLES-1, go to CAPTURE.
  - CAPTURE (1 cycle): {hi,lo} <= mul_result at end of cycle; done = 1; go to IDLE.
- mul_dataA/mul_dataB hold the operand registers in all states from LOAD until the next MULT.
- busy = 1 in LOAD, RUN and CAPTURE.
- MULT latency: accepted at edge T, LOAD in cycle T+1, RUN for CYCLES cycles, CAPTURE in cycle T+2+CYCLES. New hi/lo are visible from T+3+CYCLES. req_ready returns in that same cycle.
- MFHI/MFLO interlock: issued while busy, it stalls via req_ready = 0 and then returns the new product's HI/LO. No stale read is possible.
- Back-to-back MULT is accepted in the first IDLE cycle after CAPTURE. There are no overlapping operations.
- Reset mid-operation: abort immediately to IDLE with the reset values above. The multiplier is left unloaded; the next MULT reloads it.
- counter width is $clog2(CYCLES)+1. It never wraps within one operation.

Optional Feature:
SIGNED_MULT_EN
- Defined:
  - At accept, operand registers store magnitudes (two's-complement negate when bit WIDTH-1 = 1).
  - A sign flag = a[WIDTH-1] ^ b[WIDTH-1] is stored.
  - In CAPTURE, if the sign flag is set, {hi,lo} <= -mul_result (64-bit two's complement); otherwise mul_result.
  - The most negative operand (0x80000000) is handled correctly: its magnitude is 2^31, held unsigned.
- Undefined: operands and product are treated as unsigned, and no sign logic is synthesized.

Decomposition:
- Package mult_pkg holds:
  - opcode constants MULT_OP, MFHI_OP, MFLO_OP;
  - state enum {IDLE, LOAD, RUN, CAPTURE};
  - WIDTH and CYCLES defaults.
- One sub-module, mult_sign_fix: a combinational magnitude/negate helper, instantiated only under SIGNED_MULT_EN.

Test Plan:
- MULT a=3, b=5 -> busy for 34 cycles, then done pulse; hi=0, lo=15; mul_load high exactly 1 cycle.
- MULT a=0xFFFFFFFF, b=0xFFFFFFFF (unsigned) -> hi=0xFFFFFFFE, lo=0x00000001.
- MFHI with req_valid held during a busy MULT 0x10000*0x10000 -> req_ready=0 until after done; rd_data=0x00000001 with one rd_valid pulse. A following MFLO returns 0.
- reset=0 during RUN at counter=10 -> all outputs 0 asynchronously. Then MULT 7*6 -> lo=42, hi=0.
- Back-to-back MULT 2*2 then 9*9 with req_valid held -> second accepted in the first IDLE cycle; lo=4 at the first done, lo=81 at the second done.
- SIGNED_MULT_EN defined: MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000*2 -> hi=0xFFFFFFFF, lo=0x00000000.

Source files
------------

// File: rtl/mult_hilo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mult_pkg
// Description : Opcodes, state encoding and default sizes for mult_hilo_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_CYCLES = 32;

    localparam logic [5:0] MULT_OP = 6'd25;
    localparam logic [5:0] MFHI_OP = 6'd16;
    localparam logic [5:0] MFLO_OP = 6'd18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mult_hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : mult_hilo_ctrl_if
// Description : Request/response bus between decode stage and mult_hilo_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_hilo_ctrl_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       signal;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output req_valid, signal, src_a, src_b,
        input  req_ready, rd_data, rd_valid, done, busy, hi, lo
    );

    modport slave (
        input  req_valid, signal, src_a, src_b,
        output req_ready, rd_data, rd_valid, done, busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mult_hilo_ctrl_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : mult_sign_fix
// Description : Conditional two's-complement negate (magnitude / sign restore).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sign_fix #(
    parameter int W = 32
) (
    input  wire [W-1:0] val_i,
    input  wire         neg_i,
    output logic [W-1:0] val_o
);
    always_comb val_o = neg_i ? (~val_i + 1'b1) : val_i;
endmodule
`default_nettype wire

// File: rtl/mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_hilo_ctrl
// Description : Sequencer for a 32-iteration shift-add multiplier with HI/LO.
//               Optional signed mode enabled by defining SIGNED_MULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_hilo_ctrl #(
    parameter int         WIDTH   = mult_pkg::DEFAULT_WIDTH,
    parameter int         CYCLES  = mult_pkg::DEFAULT_CYCLES,
    parameter logic [5:0] MULT_OP = mult_pkg::MULT_OP,
    parameter logic [5:0] MFHI_OP = mult_pkg::MFHI_OP,
    parameter logic [5:0] MFLO_OP = mult_pkg::MFLO_OP
) (
    input  wire                  clk,
    input  wire                  reset,
    mult_hilo_ctrl_if.slave      bus,
    output logic                 mul_load,
    output logic [2*WIDTH-1:0]   mul_dataA,
    output logic [WIDTH-1:0]     mul_dataB,
    input  wire  [2*WIDTH-1:0]   mul_result
);
    import mult_pkg::*;

    localparam int               CNT_W    = $clog2(CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               ready, busy, done, mult_acc;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] product;

    assign mult_acc = (state_q == IDLE) && bus.req_valid && (bus.signal == MULT_OP);

`ifdef SIGNED_MULT_EN
    logic sign_q;

    mult_sign_fix #(.W(WIDTH)) u_fix_a (
        .val_i(bus.src_a), .neg_i(bus.src_a[WIDTH-1]), .val_o(mag_a)
    );
    mult_sign_fix #(.W(WIDTH)) u_fix_b (
        .val_i(bus.src_b), .neg_i(bus.src_b[WIDTH-1]), .val_o(mag_b)
    );
    mult_sign_fix #(.W(2*WIDTH)) u_fix_p (
        .val_i(mul_result), .neg_i(sign_q), .val_o(product)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q <= 1'b0;
        end else if (mult_acc) begin
            sign_q <= bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
        end
    end
`else
    assign mag_a   = bus.src_a;
    assign mag_b   = bus.src_b;
    assign product = mul_result;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mul_load   = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        ready      = 1'b0;
        case (state_q)
            IDLE: begin
                busy  = 1'b0;
                // Held low while reset is asserted so nothing is accepted then.
                ready = reset;
                if (bus.req_valid) begin
                    if (mult_acc) begin
                        op_a_d  = mag_a;
                        op_b_d  = mag_b;
                        state_d = LOAD;
                    end else if (bus.signal == MFHI_OP) begin
                        rd_data_d  = hi_q;
                        rd_valid_d = 1'b1;
                    end else if (bus.signal == MFLO_OP) begin
                        rd_data_d  = lo_q;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                mul_load = 1'b1;
                cnt_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = CAPTURE;
            end
            CAPTURE: begin
                done         = 1'b1;
                {hi_d, lo_d} = product;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mul_dataA    = {{WIDTH{1'b0}}, op_a_q};
    assign mul_dataB    = op_b_q;
    assign bus.req_ready = ready;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_hilo_ctrl
// Description : Directed self-checking bench for mult_hilo_ctrl with a
//               cycle-accurate shift-add multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mul_load;
    logic [63:0] mul_dataA;
    logic [31:0] mul_dataB;
    logic [63:0] mul_result;

    int n_vec = 0;
    int n_err = 0;

    mult_hilo_ctrl_if #(.WIDTH(32)) bus ();

    mult_hilo_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mul_load  (mul_load),
        .mul_dataA (mul_dataA),
        .mul_dataB (mul_dataB),
        .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    // Shift-add multiplier: one iteration per cycle after the load cycle.
    logic [63:0] m_acc = '0, m_cand = '0;
    logic [31:0] m_plier = '0;
    always @(posedge clk) begin
        if (mul_load) begin
            m_acc   <= '0;
            m_cand  <= mul_dataA;
            m_plier <= mul_dataB;
        end else begin
            if (m_plier[0]) m_acc <= m_acc + m_cand;
            m_cand  <= m_cand << 1;
            m_plier <= m_plier >> 1;
        end
    end
    assign mul_result = m_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 200 && !bus.req_ready; i++) tick();
        if (i == 200) check_eq("ready_timeout", bus.req_ready, 1);
    endtask

    task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.signal    = 6'd25;
        bus.src_a     = a;
        bus.src_b     = b;
        wait_ready();
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic issue_read(input logic [5:0] op);
        bus.req_valid = 1'b1;
        bus.signal    = op;
        wait_ready();
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Runs from the LOAD cycle until one cycle past the done pulse.
    task automatic wait_done(output int busy_c, output int load_c, output int rdy_c, output int done_c);
        logic seen;
        busy_c = 0; load_c = 0; rdy_c = 0; done_c = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.busy)      busy_c++;
            if (mul_load)      load_c++;
            if (bus.req_ready) rdy_c++;
            if (bus.done)      done_c++;
            seen = bus.done;
            tick();
            if (seen) break;
        end
        if (!seen) check_eq("done_timeout", 0, 1);
    endtask

    int bc, lc, rc, dc;

    initial begin
        bus.req_valid = 1'b0;
        bus.signal    = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;

        tick(); tick();
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_busy",  bus.busy, 0);
        check_eq("rst_hilo",  {bus.hi, bus.lo}, 0);
        check_eq("rst_rdv",   bus.rd_valid, 0);
        check_eq("rst_load",  mul_load, 0);
        reset = 1'b1;
        tick();
        check_eq("idle_ready", bus.req_ready, 1);

        // 3 * 5
        start_mult(32'd3, 32'd5);
        wait_done(bc, lc, rc, dc);
        check_eq("m1_busy_cycles", bc, 34);
        check_eq("m1_load_cycles", lc, 1);
        check_eq("m1_done_cycles", dc, 1);
        check_eq("m1_hi", bus.hi, 0);
        check_eq("m1_lo", bus.lo, 15);
        check_eq("m1_ready_back", bus.req_ready, 1);

`ifndef SIGNED_MULT_EN
        start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc, lc, rc, dc);
        check_eq("m2_hi", bus.hi, 64'hFFFF_FFFE);
        check_eq("m2_lo", bus.lo, 64'h0000_0001);
`endif

        // MFHI held during a busy MULT stalls and reads the new product.
        start_mult(32'h0001_0000, 32'h0001_0000);
        bus.req_valid = 1'b1;
        bus.signal    = 6'd16;
        wait_done(bc, lc, rc, dc);
        check_eq("mfhi_stall_ready", rc, 0);
        check_eq("mfhi_ready_after", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check_eq("mfhi_rdv",  bus.rd_valid, 1);
        check_eq("mfhi_data", bus.rd_data, 1);
        tick();
        check_eq("mfhi_pulse", bus.rd_valid, 0);
        issue_read(6'd18);
        check_eq("mflo_rdv",  bus.rd_valid, 1);
        check_eq("mflo_data", bus.rd_data, 0);
        tick();
        issue_read(6'd5);
        check_eq("badop_rdv", bus.rd_valid, 0);

        // Asynchronous reset in RUN with counter at 10.
        start_mult(32'h0001_2345, 32'h0000_6789);
        for (int i = 0; i < 11; i++) tick();
        check_eq("pre_rst_busy", bus.busy, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_busy",  bus.busy, 0);
        check_eq("arst_ready", bus.req_ready, 0);
        check_eq("arst_hi",    bus.hi, 0);
        check_eq("arst_dataA", mul_dataA, 0);
        check_eq("arst_dataB", mul_dataB, 0);
        check_eq("arst_done",  bus.done, 0);
        tick();
        reset = 1'b1;
        start_mult(32'd7, 32'd6);
        wait_done(bc, lc, rc, dc);
        check_eq("m4_hi", bus.hi, 0);
        check_eq("m4_lo", bus.lo, 42);

        // Back-to-back MULT with req_valid held.
        start_mult(32'd2, 32'd2);
        bus.req_valid = 1'b1;
        bus.src_a     = 32'd9;
        bus.src_b     = 32'd9;
        wait_done(bc, lc, rc, dc);
        check_eq("b2b_lo1",    bus.lo, 4);
        check_eq("b2b_ready",  bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check_eq("b2b_load2",  mul_load, 1);
        wait_done(bc, lc, rc, dc);
        check_eq("b2b_busy2",  bc, 34);
        check_eq("b2b_lo2",    bus.lo, 81);

`ifdef SIGNED_MULT_EN
        start_mult(32'hFFFF_FFFD, 32'd5);
        wait_done(bc, lc, rc, dc);
        check_eq("s1_hi", bus.hi, 64'hFFFF_FFFF);
        check_eq("s1_lo", bus.lo, 64'hFFFF_FFF1);
        start_mult(32'h8000_0000, 32'd2);
        wait_done(bc, lc, rc, dc);
        check_eq("s2_hi", bus.hi, 64'hFFFF_FFFF);
        check_eq("s2_lo", bus.lo, 64'h0000_0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
